// File: rtl/run_mode_hit_decoder_pkg.sv
// Shared constants, state encoding and the J table for the run-mode coder pair.
package run_mode_hit_decoder_pkg;

  localparam int runcount_length = 14;
  localparam int J_length        = 4;
  localparam int runindex_width  = 5;

  // rg = 1 << J reaches 2^15, so it needs 16 bits; a remainder carries at most 15 bits.
  localparam int rg_width  = 1 << J_length;
  localparam int rem_width = (1 << J_length) - 1;
  // One bit wider than the widest operand so run_length + remainder cannot wrap before the clamp.
  localparam int sum_width = ((rg_width > runcount_length) ? rg_width : runcount_length) + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIT  = 2'd1,
    ST_REM  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Entry for RUNindex 31 sits in the top nibble.
  localparam logic [J_length*32-1:0] J_TABLE_PACKED = {
    4'd15, 4'd14, 4'd13, 4'd12, 4'd11, 4'd10, 4'd9, 4'd8,
    4'd7,  4'd7,  4'd6,  4'd6,  4'd5,  4'd5,  4'd4, 4'd4,
    4'd3,  4'd3,  4'd3,  4'd3,  4'd2,  4'd2,  4'd2, 4'd2,
    4'd1,  4'd1,  4'd1,  4'd1,  4'd0,  4'd0,  4'd0, 4'd0
  };

  function automatic logic [J_length-1:0] j_lookup(input logic [runindex_width-1:0] idx);
    return J_TABLE_PACKED[idx*J_length +: J_length];
  endfunction

endpackage

// File: rtl/run_mode_hit_decoder_if.sv
// Control, bitstream and result handshake between the bit source and the run-mode decoder.
interface run_mode_hit_decoder_if;
  import run_mode_hit_decoder_pkg::*;

  logic                        clear_index;
  logic                        start;
  logic [runcount_length-1:0]  line_remaining;
  logic                        bit_in;
  logic                        bit_valid;
  logic                        bit_ready;
  logic                        run_valid;
  logic                        run_ready;
  logic [runcount_length-1:0]  run_length;
  logic                        run_interrupted;
  logic [runindex_width-1:0]   run_index;

  modport master (
    output clear_index, start, line_remaining, bit_in, bit_valid, run_ready,
    input  bit_ready, run_valid, run_length, run_interrupted, run_index
  );

  modport slave (
    input  clear_index, start, line_remaining, bit_in, bit_valid, run_ready,
    output bit_ready, run_valid, run_length, run_interrupted, run_index
  );
endinterface

// File: rtl/run_mode_hit_decoder_run_j_table.sv
// RUNindex -> (J, rg) lookup; purely combinational so the encoder can share it.
module run_j_table
  import run_mode_hit_decoder_pkg::*;
(
  input  logic [runindex_width-1:0] run_index,
  output logic [J_length-1:0]       j,
  output logic [rg_width-1:0]       rg
);

  // Table read and run-granule expansion.
  always_comb begin
    j  = j_lookup(run_index);
    rg = rg_width'(1) << j;
  end

endmodule

// File: rtl/run_mode_hit_decoder.sv
// Run-mode hit decoder: rebuilds run length and interruption flag from the serial
// hit/terminator/remainder bitstream and keeps RUNindex across runs of a scan.
// run_index follows the live RUNindex; in DONE that is the value the run ended with.
//
// state | meaning
// IDLE  | waiting for start
// HIT   | consuming hit '1' bits until '0' or end of line
// REM   | shifting in J[RUNindex] remainder bits, MSB first
// DONE  | result presented, waiting for run_ready
module run_mode_hit_decoder
  import run_mode_hit_decoder_pkg::*;
(
  input logic                    clk,
  input logic                    rst_n,
  run_mode_hit_decoder_if.slave  bus
);

  state_t                      state, state_next;
  logic [runcount_length-1:0]  line_rem, run_len;
  logic                        run_int;
  logic [runindex_width-1:0]   run_idx;
  logic [J_length-1:0]         rem_cnt, j_cur;
  logic [rem_width-1:0]        rem_val, rem_shift;
  logic [rg_width-1:0]         rg_cur;
  logic [sum_width-1:0]        line_ext, avail, hit_cnt, hit_sum, rem_sum;
  logic                        bit_fire, hit_full, hit_end, last_rem, rem_over;

  run_j_table u_j_table (
    .run_index (run_idx),
    .j         (j_cur),
    .rg        (rg_cur)
  );

  // Per-bit arithmetic: clipped hit count, remainder shift and clamp detection.
  always_comb begin
    line_ext  = sum_width'(line_rem);
    avail     = line_ext - sum_width'(run_len);
    hit_cnt   = (sum_width'(rg_cur) < avail) ? sum_width'(rg_cur) : avail;
    hit_sum   = sum_width'(run_len) + hit_cnt;
    hit_full  = (hit_cnt == sum_width'(rg_cur));
    hit_end   = (hit_sum == line_ext);
    rem_shift = {rem_val[rem_width-2:0], bus.bit_in};
    rem_sum   = sum_width'(run_len) + sum_width'(rem_shift);
    rem_over  = (rem_sum > line_ext);
    last_rem  = (rem_cnt == J_length'(1));
    bit_fire  = bus.bit_valid && ((state == ST_HIT) || (state == ST_REM));
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next-state decode.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (bus.start) state_next = (bus.line_remaining == '0) ? ST_DONE : ST_HIT;
      ST_HIT:  if (bit_fire) begin
                 if (bus.bit_in) state_next = hit_end ? ST_DONE : ST_HIT;
                 else            state_next = (j_cur == '0) ? ST_DONE : ST_REM;
               end
      ST_REM:  if (bit_fire && last_rem) state_next = ST_DONE;
      ST_DONE: if (bus.run_ready) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Moore outputs.
  always_comb begin
    bus.bit_ready       = (state == ST_HIT) || (state == ST_REM);
    bus.run_valid       = (state == ST_DONE);
    bus.run_length      = run_len;
    bus.run_interrupted = run_int;
    bus.run_index       = run_idx;
  end

  // Run accumulators: latched line length, running length, remainder shifter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_rem <= '0;
      run_len  <= '0;
      run_int  <= 1'b0;
      rem_cnt  <= '0;
      rem_val  <= '0;
    end else begin
      case (state)
        ST_IDLE: if (bus.start) begin
                   line_rem <= bus.line_remaining;
                   run_len  <= '0;
                   run_int  <= 1'b0;
                 end
        ST_HIT:  if (bit_fire) begin
                   if (bus.bit_in) begin
                     run_len <= hit_sum[runcount_length-1:0];
                   end else begin
                     run_int <= (j_cur == '0);
                     rem_cnt <= j_cur;
                     rem_val <= '0;
                   end
                 end
        ST_REM:  if (bit_fire) begin
                   rem_val <= rem_shift;
                   rem_cnt <= rem_cnt - J_length'(1);
                   if (last_rem) begin
                     run_len <= rem_over ? line_rem : rem_sum[runcount_length-1:0];
                     run_int <= 1'b1;
                   end
                 end
        default: ;
      endcase
    end
  end

  // RUNindex: grows on full hits, shrinks once per accepted interrupted run; clear has priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_idx <= '0;
    end else if (bus.clear_index) begin
      run_idx <= '0;
    end else if ((state == ST_HIT) && bit_fire && bus.bit_in && hit_full && (run_idx != '1)) begin
      run_idx <= run_idx + runindex_width'(1);
    end else if ((state == ST_DONE) && bus.run_ready && run_int && (run_idx != '0)) begin
      run_idx <= run_idx - runindex_width'(1);
    end
  end

endmodule

// File: doc/run_mode_hit_decoder.md
Name: run_mode_hit_decoder

Overview:
- Decoder counterpart of the run-mode hit encoder in the JPEG-LS datapath.
- Consumes the serial run-mode bitstream one bit per handshake: hit '1' bits, then the terminating '0', then J[RUNindex] remainder bits.
- Reconstructs the run length and the interruption flag for the pixel reconstruction stage.
- Owns the RUNindex state, which persists across runs within a scan.

Parameters:
- runcount_length, 14, width of run length and line_remaining.
- J_length, 4, width of a J table entry (max J = 15).
- runindex_width, 5, width of RUNindex (0..31).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- clear_index  input  1  synchronous pulse; RUNindex <= 0 (scan start).
- start  input  1  pulse; begin decoding one run (sampled in IDLE only).
- line_remaining  input  runcount_length  pixels left to end of line, sampled on start.
- bit_in  input  1  next bitstream bit, first-transmitted first.
- bit_valid  input  1  bit_in valid.
- bit_ready  output  1  decoder accepts a bit this cycle.
- run_valid  output  1  result valid.
- run_ready  input  1  downstream accepts result.
- run_length  output  runcount_length  decoded run length.
- run_interrupted  output  1  1 = run ended by an interruption pixel; 0 = ended at end of line.
- run_index  output  runindex_width  RUNindex in effect when the run ended.

Behaviour:
- Reset values: all outputs 0; state IDLE; RUNindex 0; internal accumulators 0.
- rg = 1 << J[RUNindex], with J = {0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,4,4,5,5,6,6,7,7,8,9,10,11,12,13,14,15}.
- A bit transfers only when bit_valid && bit_ready.
- IDLE: bit_ready=0.
  - start with line_remaining==0 -> DONE; run_length=0, run_interrupted=0.
  - start otherwise -> HIT; latch line_remaining; run_length=0.
- HIT: bit_ready=1.
  - Bit '1': cnt = min(rg, line_remaining - run_length); run_length += cnt.
  - If cnt==rg and RUNindex<31, RUNindex++ (saturates at 31).
  - If run_length now equals line_remaining -> DONE, run_interrupted=0. Otherwise stay in HIT.
  - Bit '0': if J[RUNindex]==0 -> DONE, run_interrupted=1. Else -> REM with bit counter = J[RUNindex].
- REM: bit_ready=1.
  - Shift bits MSB-first into the remainder; counter decrements per accepted bit.
  - On the last bit: run_length += remainder -> DONE, run_interrupted=1.
- DONE: bit_ready=0; run_valid=1, outputs held stable until run_ready.
  - On handshake: if run_interrupted and RUNindex>0, RUNindex--; -> IDLE.
  - run_index reports the value before this decrement.
- Latency:
  - First bit accepted no earlier than the cycle after start.
  - run_valid rises the cycle after the final bit is accepted.
  - DONE -> IDLE takes 1 cycle; a new start is honoured in IDLE only.
- Boundaries:
  - start outside IDLE: ignored.
  - bit_valid outside HIT/REM: ignored, no bit consumed.
  - clear_index together with the DONE handshake: clear wins, RUNindex=0.
  - Arithmetic: run_length never exceeds line_remaining; internal sum is one bit wider, then clamped.
  - rst_n low mid-run: immediate return to IDLE, RUNindex=0, partial run discarded, no run_valid.
  - run_ready held low: DONE persists, no bits consumed.

Decomposition:
- Shared package/include: J table constant, runcount_length, J_length, runindex_width, state encodings.
- One sub-module: run_j_table (combinational RUNindex -> J and rg lookup), reusable by the encoder side.

Test Plan:
- RUNindex=0, start line_remaining=100, bits 1,1,0 -> run_length=2, run_interrupted=1, run_index=2; after handshake RUNindex=1.
- RUNindex=4 (J=1), line_remaining=100, bits 0,1 -> run_length=1, run_interrupted=1, run_index=4; after handshake RUNindex=3.
- RUNindex=0, line_remaining=3, bits 1,1,1 -> run_length=3, run_interrupted=0, RUNindex=3 with no decrement; bit_ready low the cycle after the third bit.
- RUNindex=8 (rg=4), line_remaining=2, bit 1 -> run_length=2, run_interrupted=0, RUNindex stays 8 (partial hit).
- RUNindex=24 (J=8), bits 0 then 8 bits 10000001 with random bit_valid gaps and run_ready held low 5 cycles -> run_length=129; outputs stable until handshake; extra bits not consumed.
- rst_n asserted mid-REM -> outputs 0, IDLE; next run decodes from RUNindex=0. clear_index in IDLE -> RUNindex=0.
